move_controller: RTL
====================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, cycles a button vector must be stable before it is accepted (minimum 2).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 12500000, hold time between auto-repeat moves (used only with MOVE_REPEAT_EN).
REQ-003 SHALL have parameters START_X, default 3'd0, and START_Y, default 2'd0, giving the reset position.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have ports btn_up, btn_down, btn_right, btn_left, input, 1 bit each: raw asynchronous push buttons, active-high.
REQ-007 SHALL have port positionx, input, 3 bits: checked next x returned by the move checker.
REQ-008 SHALL have port positiony, input, 2 bits: checked next y returned by the move checker.
REQ-009 SHALL have port dir, output, 3 bits: move command to the checker; UP=000, DOWN=001, RIGHT=010, LEFT=011, NONE=100.
REQ-010 SHALL have port valid, output, 1 bit: dir is a live move request.
REQ-011 SHALL have ports posx (3 bits) and posy (2 bits), output: current player position, fed back to the checker's posx/posy.
REQ-012 SHALL have port moved, output, 1 bit: one-cycle pulse, position changed.
REQ-013 SHALL have port blocked, output, 1 bit: one-cycle pulse, move rejected (position unchanged).

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-015 The debouncer SHALL use one shared counter: it clears whenever the synchronized 4-bit vector changes, and the stable vector loads when the count reaches DEBOUNCE_CYCLES-1.
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and HOLD.
REQ-017 IDLE -> ISSUE SHALL occur when the stable vector is nonzero; the chosen direction has priority UP > DOWN > RIGHT > LEFT and is registered on entry.
REQ-018 In ISSUE, the block SHALL drive valid=1 and dir=chosen direction for exactly one cycle; in all other states it drives valid=0 and dir=NONE.
REQ-019 On the clock edge leaving ISSUE, posx/posy SHALL load positionx/positiony, and the next state SHALL be HOLD.
REQ-020 On that same edge, moved SHALL be set if the loaded value differs from the old position, otherwise blocked SHALL be set; either flag is high for the first HOLD cycle only.
REQ-021 moved and blocked SHALL never both be high.
REQ-022 HOLD -> IDLE SHALL occur when the stable vector is all zero; a press of a second button while in HOLD is ignored until full release.
REQ-023 Coordinate arithmetic SHALL be done by the checker in modulo width (x mod 8, y mod 4); this block stores whatever the checker returns, with no clamping.
REQ-024 Button activity shorter than DEBOUNCE_CYCLES SHALL produce no ISSUE.
REQ-025 One press SHALL yield exactly one ISSUE (without MOVE_REPEAT_EN).

Reset
REQ-026 While rst_n=0, the block SHALL hold: FSM=IDLE, posx=START_X, posy=START_Y, dir=NONE, valid=0, moved=0, blocked=0, synchronizers and stable vector 0, all counters 0.
REQ-027 Reset asserted during ISSUE SHALL abort the move; the position returns to START and no pulse is emitted.
REQ-028 After rst_n deasserts, a button already held SHALL produce a move only after it has been debounced.

Configuration
REQ-029 When macro MOVE_REPEAT_EN is defined, a repeat counter SHALL run in HOLD; at REPEAT_CYCLES-1 with the same direction still stable, the FSM returns to ISSUE, and the counter clears on each ISSUE.
REQ-030 When MOVE_REPEAT_EN is undefined, the repeat counter SHALL be absent and HOLD exits only on release.

Verification (bench uses the team move checker; DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20)
REQ-031 Reset, then press btn_right for 10 cycles -> exactly one valid with dir=010; posx 0->1, posy=0; moved pulses once.
REQ-032 From (2,0), press btn_right -> checker rejects forbidden (3,0); blocked pulses, and position stays at (2,0).
REQ-033 From (0,0), press btn_up -> y wraps; position becomes (0,3) and moved pulses.
REQ-034 A 2-cycle btn_left glitch, plus btn_up and btn_left pressed together -> the glitch gives no valid; the joint press issues UP only.
REQ-035 Drop rst_n during the ISSUE cycle -> position is (START_X, START_Y), with no moved or blocked pulse.
REQ-036 With MOVE_REPEAT_EN defined, hold btn_down 50 cycles from (0,0) -> repeated ISSUEs spaced 20+ cycles apart; the position steps down while valid, and blocked pulses at (0,1)->(0,2) forbidden.

Source files
------------

// File: rtl/move_controller.sv
// -----------------------------------------------------------------------------
// move_controller
//
// Turns four raw push buttons into single-step move requests for an external
// move checker, and stores the checked position that the checker returns.
//
// Flow: 2-flop synchronizers -> shared-counter debouncer -> 3-state FSM
// (IDLE / ISSUE / HOLD). Each accepted press issues exactly one move request
// (valid=1 for one cycle); the checker's answer is latched on the edge that
// leaves ISSUE, and moved/blocked report whether the position changed.
//
// Optional feature (compile-time macro MOVE_REPEAT_EN):
//   when defined, holding the same direction re-issues the move every
//   REPEAT_CYCLES cycles while in HOLD. When undefined, HOLD is left only on
//   full release and no repeat counter exists.
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a button vector must be stable (>= 2)
//   REPEAT_CYCLES    auto-repeat interval (MOVE_REPEAT_EN only)
//   START_X/START_Y  position loaded by reset
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   btn_up/down/right/left         raw asynchronous buttons, active-high
//   positionx[2:0], positiony[1:0] checked next position from the checker
//   dir[2:0]                       move command (UP/DOWN/RIGHT/LEFT/NONE)
//   valid                          dir is a live move request
//   posx[2:0], posy[1:0]           current position (fed back to checker)
//   moved, blocked                 one-cycle result pulses
// -----------------------------------------------------------------------------
module move_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_CYCLES   = 12500000,
    parameter logic [2:0]  START_X         = 3'd0,
    parameter logic [1:0]  START_Y         = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic [2:0] positionx,
    input  logic [1:0] positiony,
    output logic [2:0] dir,
    output logic       valid,
    output logic [2:0] posx,
    output logic [1:0] posy,
    output logic       moved,
    output logic       blocked
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    typedef enum logic [2:0] {
        DIR_UP    = 3'b000,
        DIR_DOWN  = 3'b001,
        DIR_RIGHT = 3'b010,
        DIR_LEFT  = 3'b011,
        DIR_NONE  = 3'b100
    } dir_t;

    localparam int unsigned          DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]      DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    // Button vector bit order: {up, down, right, left}.
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] cand_q;
    logic [3:0] stable_q;
    logic [DB_W-1:0] db_cnt_q;

    state_t state_q, state_d;
    dir_t   dir_q;

    // Priority UP > DOWN > RIGHT > LEFT.
    function automatic dir_t pick_dir(input logic [3:0] v);
        if (v[3])      return DIR_UP;
        else if (v[2]) return DIR_DOWN;
        else if (v[1]) return DIR_RIGHT;
        else if (v[0]) return DIR_LEFT;
        else           return DIR_NONE;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (synchronizer chain works).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_up, btn_down, btn_right, btn_left};
            sync2_q <= sync1_q;
        end
    end

    // Shared debouncer: cand_q tracks the last synchronized vector; any change
    // restarts the count, and a vector unchanged for DEBOUNCE_CYCLES cycles
    // becomes the stable vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q   <= '0;
            db_cnt_q <= '0;
            stable_q <= '0;
        end else if (sync2_q != cand_q) begin
            cand_q   <= sync2_q;
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_MAX) begin
            stable_q <= cand_q;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

`ifdef MOVE_REPEAT_EN
    localparam int unsigned          RP_W   = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RP_W-1:0]      RP_MAX = RP_W'(REPEAT_CYCLES - 1);

    logic [RP_W-1:0] rep_cnt_q;

    // Runs only in HOLD, so it is cleared by every ISSUE and by IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rep_cnt_q <= '0;
        else if (state_q != S_HOLD)
            rep_cnt_q <= '0;
        else if (rep_cnt_q != RP_MAX)
            rep_cnt_q <= rep_cnt_q + 1'b1;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (stable_q != 4'b0000) state_d = S_ISSUE;
            S_ISSUE: state_d = S_HOLD;
            S_HOLD: begin
                if (stable_q == 4'b0000)
                    state_d = S_IDLE;
`ifdef MOVE_REPEAT_EN
                else if (rep_cnt_q == RP_MAX && pick_dir(stable_q) == dir_q)
                    state_d = S_ISSUE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: the request is live only during ISSUE.
    always_comb begin
        valid = (state_q == S_ISSUE);
        dir   = valid ? dir_q : DIR_NONE;
    end

    // Direction is captured on entry to ISSUE from IDLE; a repeat keeps it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dir_q <= DIR_NONE;
        else if (state_q == S_IDLE && state_d == S_ISSUE)
            dir_q <= pick_dir(stable_q);
    end

    // Position and result pulses: loaded on the edge leaving ISSUE, so the
    // pulse is visible only in the first HOLD cycle. moved and blocked are
    // complementary there and both low elsewhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posx    <= START_X;
            posy    <= START_Y;
            moved   <= 1'b0;
            blocked <= 1'b0;
        end else if (state_q == S_ISSUE) begin
            posx    <= positionx;
            posy    <= positiony;
            moved   <=  ((positionx != posx) || (positiony != posy));
            blocked <= !((positionx != posx) || (positiony != posy));
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
        end
    end

endmodule
